// File: rtl/header_field_extractor.sv
// Purpose: register every input word onto dout and copy the first HEADER_WORDS words of each frame onto headers.
// Latency: one cycle from din accept to dout/headers valid.
// Backpressure: din_ready = dout slot free and (BODY or headers slot free); combinational from the readies and registered state only.
// Optional build macro HEADER_FIELD_EXTRACTOR_STATS_EN adds the 32-bit frame_cnt output.
module header_field_extractor #(
    parameter int DATA_WIDTH   = 64,
    parameter int HEADER_WORDS = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] din_data,
    input  logic                  din_last,
    input  logic                  din_valid,
    output logic                  din_ready,
    output logic [DATA_WIDTH-1:0] dout_data,
    output logic                  dout_last,
    output logic                  dout_valid,
    input  logic                  dout_ready,
    output logic [DATA_WIDTH-1:0] headers_data,
    output logic                  headers_last,
    output logic                  headers_valid,
    input  logic                  headers_ready
`ifdef HEADER_FIELD_EXTRACTOR_STATS_EN
    ,
    output logic [31:0]           frame_cnt
`endif
);

    localparam int IDX_W = $clog2(HEADER_WORDS + 1);
    localparam logic [IDX_W-1:0] HDR_END  = IDX_W'(HEADER_WORDS);
    localparam logic [IDX_W-1:0] HDR_LAST = IDX_W'(HEADER_WORDS - 1);

    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [DATA_WIDTH-1:0] dout_data_q, dout_data_d;
    logic                  dout_last_q, dout_last_d;
    logic                  dout_valid_q, dout_valid_d;
    logic [DATA_WIDTH-1:0] hdr_data_q, hdr_data_d;
    logic                  hdr_last_q, hdr_last_d;
    logic                  hdr_valid_q, hdr_valid_d;

    logic is_hdr;
    logic dout_free;
    logic hdr_free;
    logic accept;

    // Handshake decode: HDR/BODY comes straight from idx, and the input only waits on the headers slot while in HDR.
    always_comb begin
        is_hdr    = (idx_q < HDR_END);
        dout_free = !dout_valid_q | dout_ready;
        hdr_free  = !hdr_valid_q | headers_ready;
        din_ready = dout_free & (!is_hdr | hdr_free);
        accept    = din_valid & din_ready;
    end

    // Next-state: valids drop on their own handshake; a new load in the same cycle wins and keeps valid high.
    always_comb begin
        idx_d        = idx_q;
        dout_data_d  = dout_data_q;
        dout_last_d  = dout_last_q;
        dout_valid_d = dout_valid_q;
        hdr_data_d   = hdr_data_q;
        hdr_last_d   = hdr_last_q;
        hdr_valid_d  = hdr_valid_q;

        if (dout_valid_q && dout_ready) begin
            dout_valid_d = 1'b0;
        end
        if (hdr_valid_q && headers_ready) begin
            hdr_valid_d = 1'b0;
        end

        if (accept) begin
            dout_data_d  = din_data;
            dout_last_d  = din_last;
            dout_valid_d = 1'b1;
            if (is_hdr) begin
                hdr_data_d  = din_data;
                // A short frame closes the header burst on its own last word.
                hdr_last_d  = din_last | (idx_q == HDR_LAST);
                hdr_valid_d = 1'b1;
            end
            // idx saturates at HEADER_WORDS, so BODY words leave it alone.
            if (din_last) begin
                idx_d = '0;
            end else if (is_hdr) begin
                idx_d = idx_q + IDX_W'(1);
            end
        end
    end

    // State registers; reset flushes both output slots and restarts the frame at header word 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q        <= '0;
            dout_data_q  <= '0;
            dout_last_q  <= 1'b0;
            dout_valid_q <= 1'b0;
            hdr_data_q   <= '0;
            hdr_last_q   <= 1'b0;
            hdr_valid_q  <= 1'b0;
        end else begin
            idx_q        <= idx_d;
            dout_data_q  <= dout_data_d;
            dout_last_q  <= dout_last_d;
            dout_valid_q <= dout_valid_d;
            hdr_data_q   <= hdr_data_d;
            hdr_last_q   <= hdr_last_d;
            hdr_valid_q  <= hdr_valid_d;
        end
    end

    assign dout_data     = dout_data_q;
    assign dout_last     = dout_last_q;
    assign dout_valid    = dout_valid_q;
    assign headers_data  = hdr_data_q;
    assign headers_last  = hdr_last_q;
    assign headers_valid = hdr_valid_q;

`ifdef HEADER_FIELD_EXTRACTOR_STATS_EN
    logic [31:0] frame_cnt_q, frame_cnt_d;

    // Count every accepted frame end; wraps naturally at 2^32.
    always_comb begin
        frame_cnt_d = frame_cnt_q;
        if (accept && din_last) begin
            frame_cnt_d = frame_cnt_q + 32'd1;
        end
    end

    // Frame counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_cnt_q <= '0;
        end else begin
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign frame_cnt = frame_cnt_q;
`endif

endmodule

// File: tb/tb_header_field_extractor.sv
// Purpose: scoreboard bench for header_field_extractor; stimulus pushes expected words, a negedge monitor pops and compares.
// Latency: expectations are queued at the accepting edge and matched whenever an output handshakes.
// Backpressure: readies are driven directed or randomly; input stalls are bounded by a cycle budget.
module tb_header_field_extractor;

    localparam int DW = 64;
    localparam int HW = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] din_data;
    logic          din_last;
    logic          din_valid;
    logic          din_ready;
    logic [DW-1:0] dout_data;
    logic          dout_last;
    logic          dout_valid;
    logic          dout_ready;
    logic [DW-1:0] headers_data;
    logic          headers_last;
    logic          headers_valid;
    logic          headers_ready;
`ifdef HEADER_FIELD_EXTRACTOR_STATS_EN
    logic [31:0]   frame_cnt;
`endif

    header_field_extractor #(.DATA_WIDTH(DW), .HEADER_WORDS(HW)) dut (
        .clk          (clk),
        .rst          (rst),
        .din_data     (din_data),
        .din_last     (din_last),
        .din_valid    (din_valid),
        .din_ready    (din_ready),
        .dout_data    (dout_data),
        .dout_last    (dout_last),
        .dout_valid   (dout_valid),
        .dout_ready   (dout_ready),
        .headers_data (headers_data),
        .headers_last (headers_last),
        .headers_valid(headers_valid),
        .headers_ready(headers_ready)
`ifdef HEADER_FIELD_EXTRACTOR_STATS_EN
        ,
        .frame_cnt    (frame_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int hpos     = 0;
    int tb_frames = 0;
    int seq      = 0;
    bit rnd_en   = 1'b0;

    logic [DW:0] exp_dout_q[$];
    logic [DW:0] exp_hdr_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Present one word, wait (bounded) for acceptance, then queue what each output must show.
    task automatic send_word(input logic [DW-1:0] d, input logic l);
        int n;
        n = 0;
        din_data  = d;
        din_last  = l;
        din_valid = 1'b1;
        @(negedge clk);
        while (din_ready !== 1'b1) begin
            n++;
            if (n > 300) begin
                n_checks++;
                n_fail++;
                $display("FAIL din_ready_timeout: got no accept in %0d cycles expected accept", n);
                din_valid = 1'b0;
                return;
            end
            @(negedge clk);
        end
        @(posedge clk);
        exp_dout_q.push_back({l, d});
        if (hpos < HW) exp_hdr_q.push_back({l || (hpos == HW - 1), d});
        if (l) begin
            hpos = 0;
            tb_frames++;
        end else if (hpos < HW) begin
            hpos++;
        end
        #1 din_valid = 1'b0;
    endtask

    // Monitor: every output handshake must match the head of its queue.
    always @(negedge clk) begin
        if (dout_valid === 1'b1 && dout_ready === 1'b1) begin
            if (exp_dout_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL dout_extra: got word %h expected no word", dout_data);
            end else begin
                chk("dout_word", {dout_last, dout_data}, exp_dout_q.pop_front());
            end
        end
        if (headers_valid === 1'b1 && headers_ready === 1'b1) begin
            if (exp_hdr_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL headers_extra: got word %h expected no word", headers_data);
            end else begin
                chk("headers_word", {headers_last, headers_data}, exp_hdr_q.pop_front());
            end
        end
    end

    // Random ready toggling for the soak phase.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rnd_en) begin
                dout_ready    = ($urandom_range(0, 3) != 0);
                headers_ready = ($urandom_range(0, 3) != 0);
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        logic [DW-1:0] w;
        int len;

        // Reset with a word presented that must be discarded.
        rst = 1'b1;
        dout_ready = 1'b1;
        headers_ready = 1'b1;
        din_valid = 1'b1;
        din_data = 64'hDEAD_BEEF_0000_0001;
        din_last = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_dout_valid", dout_valid, 1'b0);
        chk("rst_headers_valid", headers_valid, 1'b0);
        chk("rst_dout_data", dout_data, 64'd0);
        chk("rst_headers_data", headers_data, 64'd0);
        chk("rst_dout_last", dout_last, 1'b0);
        chk("rst_headers_last", headers_last, 1'b0);
        chk("rst_din_ready", din_ready, 1'b1);
`ifdef HEADER_FIELD_EXTRACTOR_STATS_EN
        chk("rst_frame_cnt", frame_cnt, 32'd0);
`endif
        @(posedge clk);
        #1;
        rst = 1'b0;
        din_valid = 1'b0;
        din_last = 1'b0;

        // Five-word frame at full rate.
        c0 = cyc;
        send_word(64'hD0, 1'b0);
        chk("t1_latency_valid", dout_valid, 1'b1);
        chk("t1_latency_data", dout_data, 64'hD0);
        send_word(64'hD1, 1'b0);
        send_word(64'hD2, 1'b0);
        send_word(64'hD3, 1'b0);
        send_word(64'hD4, 1'b1);
        chk("t1_cycles", cyc - c0, 5);

        // Single-word frame then a three-word frame with no gap.
        c0 = cyc;
        send_word(64'hA0, 1'b1);
        send_word(64'hB0, 1'b0);
        send_word(64'hB1, 1'b0);
        send_word(64'hB2, 1'b1);
        chk("t2_cycles", cyc - c0, 4);

`ifdef HEADER_FIELD_EXTRACTOR_STATS_EN
        while (tb_frames < 7) begin
            seq++;
            send_word({32'hF0F0_0000, 32'(seq)}, 1'b1);
        end
        chk("stats_seven", frame_cnt, 32'd7);
`endif

        // Stalled headers during a four-word frame.
        repeat (2) @(posedge clk);
        #1 headers_ready = 1'b0;
        send_word(64'hC0, 1'b0);
        din_data = 64'hC1;
        din_last = 1'b0;
        din_valid = 1'b1;
        @(negedge clk);
        chk("t3_stall_a", din_ready, 1'b0);
        @(posedge clk);
        @(negedge clk);
        chk("t3_stall_b", din_ready, 1'b0);
        @(posedge clk);
        #1 headers_ready = 1'b1;
        send_word(64'hC1, 1'b0);
        headers_ready = 1'b0;
        c0 = cyc;
        send_word(64'hC2, 1'b0);
        send_word(64'hC3, 1'b1);
        chk("t3_body_cycles", cyc - c0, 2);
        chk("t3_hdr_held", {headers_valid, headers_last, headers_data}, {1'b1, 1'b1, 64'hC1});
        headers_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        // Reset on word 3 of a six-word frame.
        send_word(64'hE0, 1'b0);
        send_word(64'hE1, 1'b0);
        send_word(64'hE2, 1'b0);
        rst = 1'b1;
        din_data = 64'hE3;
        din_last = 1'b0;
        din_valid = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        din_valid = 1'b0;
        exp_dout_q.delete();
        exp_hdr_q.delete();
        hpos = 0;
        tb_frames = 0;
        @(negedge clk);
        chk("t4_dout_valid", dout_valid, 1'b0);
        chk("t4_headers_valid", headers_valid, 1'b0);
        @(posedge clk);
        #1;
        send_word(64'hE4, 1'b0);
        chk("t4_hdr_word0", {headers_valid, headers_last, headers_data}, {1'b1, 1'b0, 64'hE4});
        send_word(64'hE5, 1'b1);
        chk("t4_hdr_word1", {headers_valid, headers_last, headers_data}, {1'b1, 1'b1, 64'hE5});

        // Random-length frames under random backpressure.
        rnd_en = 1'b1;
        for (int f = 0; f < 1000; f++) begin
            len = $urandom_range(1, 5);
            for (int i = 0; i < len; i++) begin
                seq++;
                w = {32'(seq), $urandom};
                send_word(w, i == len - 1);
            end
        end
        rnd_en = 1'b0;
        @(posedge clk);
        #2;
        dout_ready = 1'b1;
        headers_ready = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        chk("drain_dout_empty", exp_dout_q.size(), 0);
        chk("drain_headers_empty", exp_hdr_q.size(), 0);

`ifdef HEADER_FIELD_EXTRACTOR_STATS_EN
        chk("stats_total", frame_cnt, 32'(tb_frames));
        force dut.frame_cnt_q = 32'hFFFF_FFFF;
        @(posedge clk);
        #1 release dut.frame_cnt_q;
        send_word(64'h99, 1'b1);
        chk("stats_wrap", frame_cnt, 32'd0);
        repeat (3) @(posedge clk);
        #1;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
